dl11_mux: RTL and testbench

DL11_MUX -- requirements
Module: dl11_mux

---
 rtl/dcj11_pkg.sv | 52 +++++
 rtl/byte_fifo.sv | 53 +++++
 rtl/dl11_mux.sv | 197 +++++++++++++++++++
 tb/tb_dl11_mux.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/dcj11_pkg.sv
// Shared definitions for the DL11 multiplexer: CSR offsets, host register codes,
// CSR bit positions, processor bus cycle codes and the vector helper.
package dcj11_pkg;

  typedef enum logic [2:0] {
    OFF_RCSR = 3'o0,
    OFF_RBUF = 3'o2,
    OFF_XCSR = 3'o4,
    OFF_XBUF = 3'o6
  } csr_off_e;

  typedef enum logic [1:0] {
    HREG_STAT = 2'd0,
    HREG_RXD  = 2'd1,
    HREG_TXD  = 2'd2,
    HREG_CNT  = 2'd3
  } host_reg_e;

  localparam int CSR_DONE   = 7;  // DONE in RCSR, READY in XCSR
  localparam int CSR_IE     = 6;
  localparam int RBUF_OVR   = 14;
  localparam int HST_TXNE   = 7;
  localparam int HST_RXFULL = 6;
  localparam int HST_OVR    = 5;

  // J11 AIO cycle codes and bank-select codes seen by the bus front end
  typedef enum logic [3:0] {
    AIO_WORD_WRITE = 4'b0001,
    AIO_BYTE_WRITE = 4'b0011,
    AIO_GP_WRITE   = 4'b0101,
    AIO_DS_READ    = 4'b1001,
    AIO_IACK       = 4'b1101,
    AIO_GP_READ    = 4'b1110,
    AIO_NON_IO     = 4'b1111
  } aio_e;

  typedef enum logic [1:0] {
    BS_MEM     = 2'b00,
    BS_SYS_REG = 2'b01,
    BS_IO_PAGE = 2'b10,
    BS_INT_REG = 2'b11
  } bs_e;

  function automatic logic [8:0] irq_vector(logic [8:0] base, logic [2:0] ch, logic tx);
    return base + {3'b000, ch, 3'b000} + {6'b000000, tx, 2'b00};
  endfunction

  function automatic logic [7:0] sat_count(logic [8:0] c);
    return c[8] ? 8'hFF : c[7:0];
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// DEPTH x 8 synchronous FIFO with show-ahead output; a pop at full frees the
// slot for a same-cycle push, and a pop at empty is ignored.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // NOTE: storage has no reset; only pointers and count define FIFO contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state always uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/dl11_mux.sv
// Multi-channel DL11 serial emulation bridging a PDP-11 CPU bus and an Apple II
// host: per-channel RX/TX byte FIFOs, DL11 CSRs, and a vectored interrupt encoder.
module dl11_mux
  import dcj11_pkg::*;
#(
  parameter int          NCHAN    = 4,
  parameter int          DEPTH    = 16,
  parameter logic [21:0] BASE     = 22'o17776500,
  parameter logic [8:0]  VEC_BASE = 9'o300
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_init,
  input  logic        bus_sel,
  input  logic        bus_we,
  input  logic        bus_byte,
  input  logic [21:0] bus_addr,
  input  logic [15:0] bus_wdata,
  output logic        bus_hit,
  output logic [15:0] bus_rdata,
  input  logic        host_sel,
  input  logic        host_we,
  input  logic [4:0]  host_addr,
  input  logic [7:0]  host_wdata,
  output logic [7:0]  host_rdata,
  output logic        irq,
  input  logic        iack,
  output logic [8:0]  vector
);

  localparam int          NF    = 2 * NCHAN;  // even index = RX, odd = TX
  localparam int          CW    = $clog2(DEPTH) + 1;
  localparam logic [22:0] LIMIT = {1'b0, BASE} + 23'(8 * NCHAN);

  logic            run;
  logic [5:1]      offset;
  logic [2:0]      cpu_ch, h_ch;
  csr_off_e        cpu_off;
  host_reg_e       h_reg;
  logic            byte_odd, access_ok, cpu_rd, cpu_wr, host_rd, host_wr, iack_ok;
  logic [7:0]      xbuf_data;

  logic [NF-1:0]   f_push, f_pop, f_full, f_empty;
  logic [7:0]      f_dout  [NF];
  logic [CW-1:0]   f_count [NF];

  logic [NCHAN-1:0] cpu_chn, host_chn, rbuf_rd, rie_wr, xie_wr;
  logic [NCHAN-1:0] rie, xie, ovr, rx_pend, tx_pend, rx_cond_q, tx_cond_q;
  logic [NCHAN-1:0] rx_cond, tx_cond, rie_nxt, xie_nxt, ovr_nxt;
  logic [NCHAN-1:0] rx_pend_nxt, tx_pend_nxt, gnt_rx, gnt_tx;
  logic [8:0]       gnt_vec;
  logic [15:0]      cpu_data;
  logic [7:0]       host_data;

  assign bus_hit   = (bus_addr >= BASE) && ({1'b0, bus_addr} < LIMIT);
  assign offset    = 5'((bus_addr - BASE) >> 1);
  assign cpu_ch    = offset[5:3];
  assign cpu_off   = csr_off_e'({offset[2:1], 1'b0});
  assign h_ch      = host_addr[4:2];
  assign h_reg     = host_reg_e'(host_addr[1:0]);
  assign byte_odd  = bus_byte & bus_addr[0];
  assign xbuf_data = byte_odd ? bus_wdata[15:8] : bus_wdata[7:0];

  // Accesses are ignored on the first edge after reset release and whenever bus_init is up.
  assign access_ok = run & ~bus_init;
  assign cpu_rd    = access_ok & bus_sel & bus_hit & ~bus_we;
  assign cpu_wr    = access_ok & bus_sel & bus_hit & bus_we;
  assign host_rd   = access_ok & host_sel & ~host_we;
  assign host_wr   = access_ok & host_sel & host_we;
  assign iack_ok   = access_ok & iack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  for (genvar f = 0; f < NF; f++) begin : g_fifo
    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (bus_init),
      .push  (f_push[f]),
      .pop   (f_pop[f]),
      .din   ((f % 2 == 0) ? host_wdata : xbuf_data),
      .dout  (f_dout[f]),
      .full  (f_full[f]),
      .empty (f_empty[f]),
      .count (f_count[f])
    );
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    cpu_chn = '0; host_chn = '0; rbuf_rd = '0; rie_wr = '0; xie_wr = '0;
    f_push  = '0; f_pop = '0;
    for (int n = 0; n < NCHAN; n++) begin
      cpu_chn[n]    = (cpu_ch == 3'(n));
      host_chn[n]   = (h_ch == 3'(n));
      rbuf_rd[n]    = cpu_rd & cpu_chn[n] & (cpu_off == OFF_RBUF);
      rie_wr[n]     = cpu_wr & cpu_chn[n] & (cpu_off == OFF_RCSR) & ~byte_odd;
      xie_wr[n]     = cpu_wr & cpu_chn[n] & (cpu_off == OFF_XCSR) & ~byte_odd;
      f_pop[2*n]    = rbuf_rd[n];
      f_push[2*n]   = host_wr & host_chn[n] & (h_reg == HREG_RXD);
      f_push[2*n+1] = cpu_wr & cpu_chn[n] & (cpu_off == OFF_XBUF);
      f_pop[2*n+1]  = host_rd & host_chn[n] & (h_reg == HREG_TXD);
    end
  end

  // Fixed priority: lowest channel first, RX ahead of TX within a channel.
  always_comb begin
    gnt_rx = '0; gnt_tx = '0; gnt_vec = '0;
    for (int n = 0; n < NCHAN; n++) begin
      if (gnt_rx == '0 && gnt_tx == '0) begin
        if (rx_pend[n]) begin
          gnt_rx[n] = 1'b1;
          gnt_vec   = irq_vector(VEC_BASE, 3'(n), 1'b0);
        end else if (tx_pend[n]) begin
          gnt_tx[n] = 1'b1;
          gnt_vec   = irq_vector(VEC_BASE, 3'(n), 1'b1);
        end
      end
    end
  end

  // Pending bits: set on a condition edge, cleared by grant, forced low while IE is low.
  always_comb begin
    rx_cond = '0; tx_cond = '0; rie_nxt = '0; xie_nxt = '0; ovr_nxt = '0;
    rx_pend_nxt = '0; tx_pend_nxt = '0;
    for (int n = 0; n < NCHAN; n++) begin
      rx_cond[n]     = rie[n] & ~f_empty[2*n];
      tx_cond[n]     = xie[n] & ~f_full[2*n+1];
      rie_nxt[n]     = rie_wr[n] ? bus_wdata[CSR_IE] : rie[n];
      xie_nxt[n]     = xie_wr[n] ? bus_wdata[CSR_IE] : xie[n];
      ovr_nxt[n]     = (ovr[n] | (f_push[2*n] & f_full[2*n])) & ~rbuf_rd[n];
      rx_pend_nxt[n] = ((rx_pend[n] & ~(iack_ok & gnt_rx[n])) | (rx_cond[n] & ~rx_cond_q[n]))
                       & rie_nxt[n];
      tx_pend_nxt[n] = ((tx_pend[n] & ~(iack_ok & gnt_tx[n])) | (tx_cond[n] & ~tx_cond_q[n]))
                       & xie_nxt[n];
    end
  end

  always_comb begin
    cpu_data = '0; host_data = '0;
    for (int n = 0; n < NCHAN; n++) begin
      if (cpu_rd && cpu_chn[n]) begin
        case (cpu_off)
          OFF_RCSR: begin
            cpu_data[CSR_DONE] = ~f_empty[2*n];
            cpu_data[CSR_IE]   = rie[n];
          end
          OFF_RBUF: if (!f_empty[2*n]) begin
            cpu_data[7:0]      = f_dout[2*n];
            cpu_data[RBUF_OVR] = ovr[n];
          end
          OFF_XCSR: begin
            cpu_data[CSR_DONE] = ~f_full[2*n+1];
            cpu_data[CSR_IE]   = xie[n];
          end
          default: ;
        endcase
      end
      if (host_rd && host_chn[n]) begin
        case (h_reg)
          HREG_STAT: begin
            host_data[HST_TXNE]   = ~f_empty[2*n+1];
            host_data[HST_RXFULL] = f_full[2*n];
            host_data[HST_OVR]    = ovr[n];
          end
          HREG_TXD: if (!f_empty[2*n+1]) host_data = f_dout[2*n+1];
          HREG_CNT: host_data = sat_count(9'(f_count[2*n]));
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || bus_init) begin
      rie <= '0; xie <= '0; ovr <= '0; rx_pend <= '0; tx_pend <= '0;
      rx_cond_q <= '0; tx_cond_q <= '0;
      irq <= 1'b0; bus_rdata <= '0; host_rdata <= '0; vector <= '0;
    end else begin
      rie        <= rie_nxt;
      xie        <= xie_nxt;
      ovr        <= ovr_nxt;
      rx_pend    <= rx_pend_nxt;
      tx_pend    <= tx_pend_nxt;
      rx_cond_q  <= rx_cond;
      tx_cond_q  <= tx_cond;
      irq        <= |{rx_pend_nxt, tx_pend_nxt};
      bus_rdata  <= cpu_data;
      host_rdata <= host_data;
      vector     <= iack_ok ? gnt_vec : 9'd0;
    end
  end

endmodule

// File: tb/tb_dl11_mux.sv
// Directed bench for dl11_mux: CPU/host FIFO traffic, overrun, CSR byte writes,
// interrupt priority, bus_init and asynchronous reset behaviour.
module tb_dl11_mux;

  localparam logic [21:0] BASE = 22'o17776500;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bus_init = 1'b0, bus_sel = 1'b0, bus_we = 1'b0, bus_byte = 1'b0;
  logic [21:0] bus_addr = '0;
  logic [15:0] bus_wdata = '0;
  logic        bus_hit;
  logic [15:0] bus_rdata;
  logic        host_sel = 1'b0, host_we = 1'b0;
  logic [4:0]  host_addr = '0;
  logic [7:0]  host_wdata = '0;
  logic [7:0]  host_rdata;
  logic        irq;
  logic        iack = 1'b0;
  logic [8:0]  vector;

  int tests = 0;
  int fails = 0;

  dl11_mux dut (
    .clk(clk), .rst_n(rst_n), .bus_init(bus_init), .bus_sel(bus_sel), .bus_we(bus_we),
    .bus_byte(bus_byte), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_hit(bus_hit),
    .bus_rdata(bus_rdata), .host_sel(host_sel), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .irq(irq), .iack(iack), .vector(vector)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] ha(input int ch, input int r);
    return 5'(ch * 4 + r);
  endfunction

  task automatic cpu_wr(input logic [21:0] a, input logic [15:0] d, input logic byt);
    @(negedge clk);
    bus_sel = 1'b1; bus_we = 1'b1; bus_byte = byt; bus_addr = a; bus_wdata = d;
    @(posedge clk); #1;
    bus_sel = 1'b0; bus_we = 1'b0; bus_byte = 1'b0;
  endtask

  task automatic cpu_rd(input logic [21:0] a, output logic [15:0] d);
    @(negedge clk);
    bus_sel = 1'b1; bus_we = 1'b0; bus_addr = a;
    @(posedge clk); #1;
    bus_sel = 1'b0;
    d = bus_rdata;
  endtask

  task automatic host_wr(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    host_sel = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
    @(posedge clk); #1;
    host_sel = 1'b0; host_we = 1'b0;
  endtask

  task automatic host_rd(input logic [4:0] a, output logic [7:0] d);
    @(negedge clk);
    host_sel = 1'b1; host_we = 1'b0; host_addr = a;
    @(posedge clk); #1;
    host_sel = 1'b0;
    d = host_rdata;
  endtask

  task automatic do_iack(output logic [8:0] v);
    @(negedge clk);
    iack = 1'b1;
    @(posedge clk); #1;
    iack = 1'b0;
    v = vector;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d16;
    logic [7:0]  d8;
    logic [8:0]  v;

    // Held in reset
    #10;
    check("rst_irq", 32'(irq), 0);
    check("rst_vector", 32'(vector), 0);
    check("rst_bus_rdata", 32'(bus_rdata), 0);
    check("rst_host_rdata", 32'(host_rdata), 0);

    // Host push held across release: only the second edge after release takes it
    #11;
    host_sel = 1'b1; host_we = 1'b1; host_addr = ha(0, 1); host_wdata = 8'h55;
    #1 rst_n = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    host_sel = 1'b0; host_we = 1'b0;
    host_rd(ha(0, 3), d8);  check("sync_count", 32'(d8), 1);
    cpu_rd(BASE + 22'o2, d16); check("sync_rbuf", 32'(d16), 32'h0055);

    // Address window
    bus_addr = BASE + 22'o37; #1 check("hit_last", 32'(bus_hit), 1);
    bus_addr = BASE + 22'o40; #1 check("hit_above", 32'(bus_hit), 0);
    bus_addr = BASE - 22'd1;  #1 check("hit_below", 32'(bus_hit), 0);

    // Host -> CPU on channel 2
    host_wr(ha(2, 1), 8'h41);
    cpu_rd(BASE + 22'o20, d16); check("ch2_rcsr_done", 32'(d16), 32'o200);
    cpu_rd(BASE + 22'o22, d16); check("ch2_rbuf", 32'(d16), 32'h0041);
    cpu_rd(BASE + 22'o20, d16); check("ch2_rcsr_empty", 32'(d16), 0);

    // CPU -> host on channel 0, fill to full and drop the 17th
    for (int i = 0; i < 16; i++) cpu_wr(BASE + 22'o6, 16'(8'h10 + i), 1'b0);
    cpu_rd(BASE + 22'o4, d16); check("ch0_xcsr_full", 32'(d16), 0);
    cpu_wr(BASE + 22'o6, 16'h00EE, 1'b0);
    host_rd(ha(0, 0), d8); check("ch0_host_stat", 32'(d8), 32'h80);
    for (int i = 0; i < 16; i++) begin
      host_rd(ha(0, 2), d8); check($sformatf("ch0_pop%0d", i), 32'(d8), 32'(8'h10 + i));
    end
    host_rd(ha(0, 2), d8); check("ch0_pop_empty", 32'(d8), 0);
    cpu_rd(BASE + 22'o4, d16); check("ch0_xcsr_ready", 32'(d16), 32'o200);

    // CSR byte writes: odd byte ignored, even byte updates IE
    cpu_wr(BASE + 22'o1, 16'h4040, 1'b1);
    cpu_rd(BASE, d16); check("byte_odd_ignored", 32'(d16), 0);
    cpu_wr(BASE, 16'h0040, 1'b1);
    cpu_rd(BASE, d16); check("byte_even_rie", 32'(d16), 32'o100);
    cpu_wr(BASE, 16'h0000, 1'b0);

    // RX overrun on channel 1
    for (int i = 0; i < 17; i++) host_wr(ha(1, 1), 8'(8'h60 + i));
    host_rd(ha(1, 0), d8); check("ch1_stat_ovr", 32'(d8), 32'h60);
    host_rd(ha(1, 3), d8); check("ch1_count_full", 32'(d8), 16);
    cpu_rd(BASE + 22'o12, d16); check("ch1_rbuf_ovr", 32'(d16), 32'h4060);
    cpu_rd(BASE + 22'o12, d16); check("ch1_rbuf_next", 32'(d16), 32'h0061);
    for (int i = 2; i < 16; i++) cpu_rd(BASE + 22'o12, d16);
    check("ch1_rbuf_last", 32'(d16), 32'h006F);
    cpu_rd(BASE + 22'o12, d16); check("ch1_rbuf_empty", 32'(d16), 0);

    // Full RX: simultaneous push and pop
    for (int i = 0; i < 16; i++) host_wr(ha(1, 1), 8'(8'h70 + i));
    @(negedge clk);
    host_sel = 1'b1; host_we = 1'b1; host_addr = ha(1, 1); host_wdata = 8'hAB;
    bus_sel = 1'b1; bus_we = 1'b0; bus_addr = BASE + 22'o12;
    @(posedge clk); #1;
    host_sel = 1'b0; host_we = 1'b0; bus_sel = 1'b0;
    check("full_pushpop_data", 32'(bus_rdata), 32'h0070);
    host_rd(ha(1, 3), d8); check("full_pushpop_count", 32'(d8), 16);
    host_rd(ha(1, 0), d8); check("full_pushpop_stat", 32'(d8), 32'h40);
    for (int i = 1; i < 16; i++) cpu_rd(BASE + 22'o12, d16);
    check("full_pushpop_pen", 32'(d16), 32'h007F);
    cpu_rd(BASE + 22'o12, d16); check("full_pushpop_tail", 32'(d16), 32'h00AB);

    // Empty RX: simultaneous push and pop on channel 3
    @(negedge clk);
    host_sel = 1'b1; host_we = 1'b1; host_addr = ha(3, 1); host_wdata = 8'h33;
    bus_sel = 1'b1; bus_we = 1'b0; bus_addr = BASE + 22'o32;
    @(posedge clk); #1;
    host_sel = 1'b0; host_we = 1'b0; bus_sel = 1'b0;
    check("empty_pushpop_data", 32'(bus_rdata), 0);
    host_rd(ha(3, 3), d8); check("empty_pushpop_count", 32'(d8), 1);

    // Interrupt priority: ch3 RX, ch1 RX, ch1 TX pending
    host_wr(ha(1, 1), 8'h11);
    cpu_wr(BASE + 22'o30, 16'o100, 1'b0);
    cpu_wr(BASE + 22'o10, 16'o100, 1'b0);
    cpu_wr(BASE + 22'o14, 16'o100, 1'b0);
    repeat (2) @(posedge clk); #1;
    check("irq_asserted", 32'(irq), 1);
    do_iack(v); check("iack1_vec", 32'(v), 32'o310);
    do_iack(v); check("iack2_vec", 32'(v), 32'o314);
    do_iack(v); check("iack3_vec", 32'(v), 32'o330);
    check("irq_drained", 32'(irq), 0);
    do_iack(v); check("iack_none_vec", 32'(v), 0);

    // Clearing IE drops the pending request
    cpu_wr(BASE + 22'o14, 16'o000, 1'b0);
    cpu_wr(BASE + 22'o14, 16'o100, 1'b0);
    repeat (2) @(posedge clk); #1;
    check("xie_reset_irq", 32'(irq), 1);
    cpu_wr(BASE + 22'o14, 16'o000, 1'b0);
    check("xie_clear_irq", 32'(irq), 0);

    // bus_init with pending interrupt and data everywhere
    cpu_wr(BASE + 22'o14, 16'o100, 1'b0);
    cpu_wr(BASE + 22'o6, 16'h0099, 1'b0);
    repeat (2) @(posedge clk); #1;
    check("pre_init_irq", 32'(irq), 1);
    @(negedge clk); bus_init = 1'b1;
    @(posedge clk); #1; bus_init = 1'b0;
    check("init_irq", 32'(irq), 0);
    cpu_rd(BASE + 22'o30, d16); check("init_rcsr3", 32'(d16), 0);
    cpu_rd(BASE + 22'o14, d16); check("init_xcsr1", 32'(d16), 32'o200);
    host_rd(ha(0, 0), d8); check("init_host_stat0", 32'(d8), 0);

    // Asynchronous reset in the middle of live traffic
    cpu_wr(BASE + 22'o14, 16'o100, 1'b0);
    cpu_wr(BASE + 22'o6, 16'h0022, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    host_sel = 1'b1; host_we = 1'b0; host_addr = ha(0, 0);
    bus_sel = 1'b1; bus_we = 1'b0; bus_addr = BASE + 22'o14;
    @(posedge clk); #1;
    check("pre_rst_host", 32'(host_rdata), 32'h80);
    check("pre_rst_bus", 32'(bus_rdata), 32'o300);
    check("pre_rst_irq", 32'(irq), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_irq", 32'(irq), 0);
    check("mid_rst_bus", 32'(bus_rdata), 0);
    check("mid_rst_host", 32'(host_rdata), 0);
    check("mid_rst_vector", 32'(vector), 0);
    #2;
    host_sel = 1'b0; bus_sel = 1'b0;
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    host_rd(ha(0, 0), d8); check("post_rst_host_stat0", 32'(d8), 0);
    cpu_rd(BASE + 22'o14, d16); check("post_rst_xcsr1", 32'(d16), 32'o200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
